// File: rtl/axi_verifier_top.sv
// Self-running AXI4-Lite exerciser: fetches RISC-V words, follows JAL,
// and streams every fetched word into a trace buffer on the data port.
module axi_verifier_top #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0080,
  parameter logic [31:0] TRACE_BASE  = 32'h0000_0000,
  parameter int unsigned TRACE_DEPTH = 256
) (
  input  logic        clk_100MHz,
  input  logic        reset_rtl,
  output logic [31:0] m_axi_instr_araddr,
  output logic [2:0]  m_axi_instr_arprot,
  output logic        m_axi_instr_arvalid,
  input  logic        m_axi_instr_arready,
  input  logic [31:0] m_axi_instr_rdata,
  input  logic [1:0]  m_axi_instr_rresp,
  input  logic        m_axi_instr_rvalid,
  output logic        m_axi_instr_rready,
  output logic [31:0] m_axi_data_awaddr,
  output logic [2:0]  m_axi_data_awprot,
  output logic        m_axi_data_awvalid,
  input  logic        m_axi_data_awready,
  output logic [31:0] m_axi_data_wdata,
  output logic [3:0]  m_axi_data_wstrb,
  output logic        m_axi_data_wvalid,
  input  logic        m_axi_data_wready,
  input  logic [1:0]  m_axi_data_bresp,
  input  logic        m_axi_data_bvalid,
  output logic        m_axi_data_bready,
  output logic [31:0] retired_count,
  output logic        axi_error
);

  localparam int unsigned PW = $clog2(TRACE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_AR,
    S_FETCH_R,
    S_TRACE,
    S_TRACE_B
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   ret_q, ret_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          rerr_q, rerr_d;
  logic          awdone_q, awdone_d;
  logic          wdone_q, wdone_d;

  logic          is_jal;
  logic          misalign;
  logic [31:0]   jal_imm;
  logic [31:0]   jal_tgt;
  logic [31:0]   npc;
  logic          aw_ok;
  logic          w_ok;

  // A word returned with a bad response is traced but never steers the PC.
  always_comb begin
    is_jal   = (instr_q[6:0] == 7'h6F) && !rerr_q;
    jal_imm  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                instr_q[20], instr_q[30:21], 1'b0};
    jal_tgt  = pc_q + jal_imm;
    misalign = is_jal && jal_tgt[1];
    npc      = is_jal ? (jal_tgt & ~32'd3) : pc_q + 32'd4;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ret_d    = ret_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    rerr_d   = rerr_q;
    awdone_d = awdone_q;
    wdone_d  = wdone_q;
    aw_ok    = 1'b0;
    w_ok     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH_AR;
      S_FETCH_AR: begin
        if (m_axi_instr_arready) state_d = S_FETCH_R;
      end
      S_FETCH_R: begin
        if (m_axi_instr_rvalid) begin
          instr_d = m_axi_instr_rdata;
          rerr_d  = (m_axi_instr_rresp != 2'b00);
          err_d   = err_q | (m_axi_instr_rresp != 2'b00);
          state_d = S_TRACE;
        end
      end
      S_TRACE: begin
        aw_ok    = awdone_q | m_axi_data_awready;
        w_ok     = wdone_q | m_axi_data_wready;
        awdone_d = aw_ok;
        wdone_d  = w_ok;
        if (aw_ok && w_ok) begin
          awdone_d = 1'b0;
          wdone_d  = 1'b0;
          state_d  = S_TRACE_B;
        end
      end
      S_TRACE_B: begin
        if (m_axi_data_bvalid) begin
          err_d   = err_q | (m_axi_data_bresp != 2'b00) | misalign;
          pc_d    = npc;
          ptr_d   = ptr_q + PW'(1);
          ret_d   = ret_q + 32'd1;
          state_d = S_FETCH_AR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset_rtl) begin
      state_q  <= S_IDLE;
      pc_q     <= BOOT_ADDR;
      instr_q  <= 32'd0;
      ret_q    <= 32'd0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
      rerr_q   <= 1'b0;
      awdone_q <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ret_q    <= ret_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      rerr_q   <= rerr_d;
      awdone_q <= awdone_d;
      wdone_q  <= wdone_d;
    end
  end

  assign m_axi_instr_araddr  = pc_q;
  assign m_axi_instr_arprot  = 3'b100;
  assign m_axi_instr_arvalid = (state_q == S_FETCH_AR);
  assign m_axi_instr_rready  = (state_q == S_FETCH_R);
  assign m_axi_data_awaddr   = TRACE_BASE + 32'({ptr_q, 2'b00});
  assign m_axi_data_awprot   = 3'b000;
  assign m_axi_data_awvalid  = (state_q == S_TRACE) && !awdone_q;
  assign m_axi_data_wdata    = instr_q;
  assign m_axi_data_wstrb    = 4'hF;
  assign m_axi_data_wvalid   = (state_q == S_TRACE) && !wdone_q;
  assign m_axi_data_bready   = (state_q == S_TRACE_B);
  assign retired_count       = ret_q;
  assign axi_error           = err_q;

endmodule

// File: tb/tb_axi_verifier_top.sv
// Directed bench for axi_verifier_top with delay-configurable
// instruction and data slave models.
module tb_axi_verifier_top;

  logic        clk = 1'b0;
  logic        reset_rtl = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] retired;
  logic        aerr;

  axi_verifier_top dut (
    .clk_100MHz          (clk),
    .reset_rtl           (reset_rtl),
    .m_axi_instr_araddr  (araddr),
    .m_axi_instr_arprot  (arprot),
    .m_axi_instr_arvalid (arvalid),
    .m_axi_instr_arready (arready),
    .m_axi_instr_rdata   (rdata),
    .m_axi_instr_rresp   (rresp),
    .m_axi_instr_rvalid  (rvalid),
    .m_axi_instr_rready  (rready),
    .m_axi_data_awaddr   (awaddr),
    .m_axi_data_awprot   (awprot),
    .m_axi_data_awvalid  (awvalid),
    .m_axi_data_awready  (awready),
    .m_axi_data_wdata    (wdata),
    .m_axi_data_wstrb    (wstrb),
    .m_axi_data_wvalid   (wvalid),
    .m_axi_data_wready   (wready),
    .m_axi_data_bresp    (bresp),
    .m_axi_data_bvalid   (bvalid),
    .m_axi_data_bready   (bready),
    .retired_count       (retired),
    .axi_error           (aerr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] imem [64];
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit ar_block = 1'b0;
  int err_arm = 0;
  logic [31:0] err_addr = 32'h80;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] fq[$];
  int          fcyc[$];
  logic [31:0] aq[$];
  logic [31:0] wq[$];
  int nb = 0;
  int ar_unst = 0, aw_unst = 0, w_unst = 0;
  int iprot_bad = 0, dprot_bad = 0, strb_bad = 0;

  // Instruction slave: ready/valid decided on the falling edge.
  int arw = 0, rw = 0, err_done = 0;
  bit rpend = 0, aract = 0, arf = 0, rf = 0;
  logic [31:0] raddr = 0, arcap = 0;
  always @(negedge clk) begin
    if (reset_rtl) begin
      arready = 0; rvalid = 0; rpend = 0; aract = 0;
      arf = 0; rf = 0; arw = 0; rw = 0;
    end else begin
      if (arf) begin
        fq.push_back(raddr); fcyc.push_back(cyc);
        rpend = 1; rw = 0; arready = 0; arw = 0; aract = 0;
      end
      if (rf) rvalid = 0;
      if (arvalid) begin
        if (!aract) begin aract = 1; arcap = araddr; end
        else if (araddr !== arcap) ar_unst++;
        if (arprot !== 3'b100) iprot_bad++;
        if (!arready && !ar_block) begin
          if (arw >= ar_dly) arready = 1; else arw++;
        end
      end
      if (rpend) begin
        if (rw >= r_dly) begin
          rpend = 0; rvalid = 1;
          rdata = imem[raddr[7:2]]; rresp = 2'b00;
          if (err_arm != err_done && raddr == err_addr) begin
            rresp = 2'b10; err_done = err_arm;
          end
        end else rw++;
      end
      arf = arvalid && arready;
      if (arf) raddr = araddr;
      rf = rvalid && rready;
    end
  end

  // Data slave: AW and W accepted independently, then B.
  int aww = 0, ww = 0, bw = 0;
  bit awf = 0, wf = 0, bf = 0, awd = 0, wd = 0, bpend = 0;
  bit awact = 0, wact = 0;
  logic [31:0] awcap = 0, wcap = 0;
  always @(negedge clk) begin
    if (reset_rtl) begin
      awready = 0; wready = 0; bvalid = 0; awf = 0; wf = 0; bf = 0;
      awd = 0; wd = 0; bpend = 0; awact = 0; wact = 0;
      aww = 0; ww = 0; bw = 0;
    end else begin
      if (awf) begin
        aq.push_back(awcap); awready = 0; aww = 0; awact = 0; awd = 1;
      end
      if (wf) begin
        wq.push_back(wcap); wready = 0; ww = 0; wact = 0; wd = 1;
      end
      if (bf) begin bvalid = 0; nb++; end
      if (awd && wd) begin awd = 0; wd = 0; bpend = 1; bw = 0; end
      if (awvalid) begin
        if (!awact) begin awact = 1; awcap = awaddr; end
        else if (awaddr !== awcap) aw_unst++;
        if (awprot !== 3'b000) dprot_bad++;
        if (!awready) begin
          if (aww >= aw_dly) awready = 1; else aww++;
        end
      end
      if (wvalid) begin
        if (!wact) begin wact = 1; wcap = wdata; end
        else if (wdata !== wcap) w_unst++;
        if (wstrb !== 4'hF) strb_bad++;
        if (!wready) begin
          if (ww >= w_dly) wready = 1; else ww++;
        end
      end
      if (bpend) begin
        if (bw >= b_dly) begin bpend = 0; bvalid = 1; end else bw++;
      end
      awf = awvalid && awready;
      wf  = wvalid && wready;
      bf  = bvalid && bready;
    end
  end

  int fb = 0, ab = 0, wb = 0, bb = 0;

  task automatic do_reset();
    reset_rtl = 1'b1;
    repeat (2) @(negedge clk);
    fb = fq.size(); ab = aq.size(); wb = wq.size(); bb = nb;
    reset_rtl = 1'b0;
  endtask

  task automatic wait_fetch(input int n, input string tag);
    for (int i = 0; i < 3000 && fq.size() < fb + n; i++) @(negedge clk);
    chk(tag, 32'(fq.size() >= fb + n), 32'd1);
  endtask

  function automatic logic [31:0] loop_pc(input int i);
    int k;
    k = i % 33;
    return (k == 0) ? 32'h80 : 32'(4 * (k - 1));
  endfunction

  initial begin
    logic [31:0] r33;
    bit got;
    int n;

    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    imem[32] = 32'hF81F_F06F;

    // Reset held for five cycles
    repeat (5) begin
      @(negedge clk);
      chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    end
    reset_rtl = 1'b0;
    for (int i = 0; i < 2 && !arvalid; i++) @(negedge clk);
    chk("first_arvalid", 32'(arvalid), 1);
    chk("first_araddr", araddr, 32'h80);
    chk("first_arprot", 32'(arprot), 32'd4);
    chk("rst_retired", retired, 0);
    chk("rst_err", 32'(aerr), 0);

    // Zero-wait JAL loop, run past the trace pointer wrap
    got = 0; r33 = 0;
    for (int i = 0; i < 2000 && aq.size() < 257; i++) begin
      @(negedge clk);
      if (!got && fq.size() >= 34) begin got = 1; r33 = retired; end
    end
    chk("loop_done", 32'(aq.size() >= 257 && wq.size() >= 257), 1);
    chk("retired_33", r33, 32'd33);
    for (int i = 0; i < 34; i++) chk("loop_pc", fq[i], loop_pc(i));
    chk("latency4", 32'(fcyc[2] - fcyc[1]), 32'd4);
    n = (aq.size() < 257) ? aq.size() : 257;
    if (wq.size() < n) n = wq.size();
    for (int i = 0; i < n; i++) begin
      chk("trace_addr", aq[i], 32'(4 * (i % 256)));
      chk("trace_data", wq[i], (i % 33 == 0) ? 32'hF81F_F06F : 32'h13);
    end
    chk("wrap_addr", aq[256], 32'h0);
    chk("loop_err", 32'(aerr), 0);

    // Backpressure on every channel
    ar_dly = 5; aw_dly = 1; w_dly = 4; b_dly = 4;
    do_reset();
    wait_fetch(6, "bp_progress");
    ar_block = 1'b1;
    repeat (60) @(negedge clk);
    chk("bp_fetches", 32'(fq.size() - fb), 32'd6);
    chk("bp_aw_beats", 32'(aq.size() - ab), 32'd6);
    chk("bp_w_beats", 32'(wq.size() - wb), 32'd6);
    chk("bp_b_beats", 32'(nb - bb), 32'd6);
    chk("bp_retired", retired, 32'd6);
    chk("bp_pc0", fq[fb], 32'h80);
    chk("bp_pc1", fq[fb + 1], 32'h00);
    chk("bp_pc4", fq[fb + 4], 32'h0C);
    chk("bp_awaddr5", aq[ab + 5], 32'h14);
    chk("bp_wdata0", wq[wb], 32'hF81F_F06F);
    chk("bp_wdata1", wq[wb + 1], 32'h13);
    chk("bp_period", 32'(fcyc[fb + 2] - fcyc[fb + 1]), 32'd17);

    // Error response on the JAL fetch at 0x80
    ar_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    ar_block = 1'b0;
    err_arm++;
    do_reset();
    wait_fetch(2, "rerr_progress");
    chk("rerr_flag", 32'(aerr), 1);
    wait_fetch(5, "rerr_progress2");
    ar_block = 1'b1;
    repeat (20) @(negedge clk);
    chk("rerr_pc1", fq[fb + 1], 32'h84);
    chk("rerr_pc3", fq[fb + 3], 32'h8C);
    chk("rerr_traced", wq[wb], 32'hF81F_F06F);
    chk("rerr_sticky", 32'(aerr), 1);

    // JAL +6: target 0x86 forced to 0x84
    imem[32] = 32'h0060_006F;
    ar_block = 1'b0;
    do_reset();
    chk("mis_err_clr", 32'(aerr), 0);
    wait_fetch(3, "mis_progress");
    chk("mis_pc1", fq[fb + 1], 32'h84);
    chk("mis_pc2", fq[fb + 2], 32'h88);
    chk("mis_err", 32'(aerr), 1);
    imem[32] = 32'hF81F_F06F;

    // Reset pulse while waiting on read data
    r_dly = 3;
    do_reset();
    wait_fetch(4, "fr_progress");
    for (int i = 0; i < 50 && !rready; i++) @(negedge clk);
    chk("fr_in_fetch_r", 32'(rready), 1);
    chk("fr_ret_nonzero", 32'(retired != 0), 1);
    reset_rtl = 1'b1;
    @(negedge clk);
    chk("fr_abort", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    chk("fr_retired", retired, 0);
    @(negedge clk);
    fb = fq.size(); ab = aq.size(); wb = wq.size(); bb = nb;
    reset_rtl = 1'b0;
    wait_fetch(3, "fr_restart");
    chk("fr_pc0", fq[fb], 32'h80);
    chk("fr_pc1", fq[fb + 1], 32'h00);
    chk("fr_awaddr0", aq[ab], 32'h0);
    chk("fr_awaddr1", aq[ab + 1], 32'h4);

    chk("ar_stable", 32'(ar_unst), 0);
    chk("aw_stable", 32'(aw_unst), 0);
    chk("w_stable", 32'(w_unst), 0);
    chk("arprot", 32'(iprot_bad), 0);
    chk("awprot", 32'(dprot_bad), 0);
    chk("wstrb", 32'(strb_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_verifier_top.md
Name: axi_verifier_top

Overview:
- Self-running AXI4-Lite exerciser for the instruction and data memory paths of the Kuuga bring-up system.
- After reset it fetches 32-bit RISC-V instruction words from an instruction AXI slave, starting at the boot address.
- It follows JAL control flow and writes every fetched word as a trace record to a data AXI slave.
- It sits between the top-level clock/reset and two AXI slave memory models (instruction, data).

Parameters:
- BOOT_ADDR, 32'h0000_0080, first fetch address after reset.
- TRACE_BASE, 32'h0000_0000, base byte address of the trace buffer on the data port.
- TRACE_DEPTH, 256, trace entries before the write pointer wraps; power of two, at least 2.

Ports:
- clk_100MHz  in  1  sole clock; all logic on its rising edge.
- reset_rtl  in  1  synchronous, active-high reset.
- m_axi_instr_araddr  out  32  instruction read address (= PC).
- m_axi_instr_arprot  out  3  constant 3'b100 (instruction access).
- m_axi_instr_arvalid  out  1  read address valid.
- m_axi_instr_arready  in  1  read address ready.
- m_axi_instr_rdata  in  32  instruction word.
- m_axi_instr_rresp  in  2  read response.
- m_axi_instr_rvalid  in  1  read data valid.
- m_axi_instr_rready  out  1  read data ready.
- m_axi_data_awaddr  out  32  trace write address.
- m_axi_data_awprot  out  3  constant 3'b000.
- m_axi_data_awvalid  out  1  write address valid.
- m_axi_data_awready  in  1  write address ready.
- m_axi_data_wdata  out  32  trace word (fetched instruction).
- m_axi_data_wstrb  out  4  constant 4'hF.
- m_axi_data_wvalid  out  1  write data valid.
- m_axi_data_wready  in  1  write data ready.
- m_axi_data_bresp  in  2  write response.
- m_axi_data_bvalid  in  1  write response valid.
- m_axi_data_bready  out  1  write response ready.
- retired_count  out  32  completed fetch+trace iterations; wraps mod 2^32.
- axi_error  out  1  sticky flag; set on a non-OKAY rresp/bresp or a misaligned JAL target.

Behaviour:
- Reset (sampled at the clock edge): all valid and ready outputs 0; PC=BOOT_ADDR; trace pointer=0; retired_count=0; axi_error=0; state=IDLE. A reset asserted mid-transaction aborts the transaction at the next edge.
- FSM transitions:
  - IDLE -> FETCH_AR one cycle after reset is released.
  - FETCH_AR: arvalid=1, araddr=PC; araddr is held stable until arready; on the handshake go to FETCH_R.
  - FETCH_R: rready=1; on rvalid, capture rdata into INSTR, OR (rresp!=0) into axi_error, go to TRACE.
  - TRACE: awvalid=1 and wvalid=1 assert in the same cycle; awaddr=TRACE_BASE+4*ptr, wdata=INSTR. Each valid drops independently after its own handshake (ready may arrive in either order or together). When both handshakes are done, go to TRACE_B.
  - TRACE_B: bready=1; on bvalid, OR (bresp!=0) into axi_error, update PC, ptr=(ptr+1) mod TRACE_DEPTH, retired_count+=1, go to FETCH_AR.
- Next-PC rule:
  - INSTR[6:0]==7'h6F (JAL): PC += sign-extended {INSTR[31],INSTR[19:12],INSTR[20],INSTR[30:21],1'b0}, mod 2^32.
  - All other opcodes: PC += 4, wrapping at 2^32.
  - A JAL target with bit 1 set sets axi_error and is forced to a word-aligned address (bits[1:0]=0).
- A non-OKAY rresp still traces the returned word; the next PC is then always PC+4, even if the word is a JAL.
- Exactly one outstanding read or write at a time. No combinational path from any input to any output valid signal.
- Minimum loop latency with zero-wait slaves: 4 cycles per instruction.

Test Plan:
- Reset held 5 cycles then released -> all valids 0 during reset; first arvalid with araddr=0x80 within 2 cycles of release; retired_count=0.
- Word 0x80=0xF81FF06F (JAL -128), words 0x00-0x7C=0x00000013 -> fetch addresses 0x80,0x00,0x04,...,0x7C,0x80 repeating; retired_count=33 after the first full loop; axi_error=0.
- Trace check -> awaddr 0x0,0x4,0x8,...; wdata matches each fetched word; entry 256 writes 0x0 again; wstrb=0xF.
- Backpressure: arready delayed 5 cycles, wready 3 cycles after awready, bvalid delayed 4 cycles -> araddr/awaddr/wdata stable while valid; exactly one beat per handshake.
- rresp=2'b10 on the fetch at 0x80 -> axi_error=1 and stays 1; next fetch at 0x84, not 0x00.
- reset_rtl pulsed during FETCH_R -> next cycle all valids and readies 0; fetch restarts at 0x80 with ptr=0 and retired_count=0.
